fetch_unit: RTL



---
 rtl/jsilicon_pkg.sv | 29 ++
 rtl/fetch_imem.sv | 37 +++
 rtl/fetch_unit.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/jsilicon_pkg.sv
// -----------------------------------------------------------------------------
// jsilicon_pkg
// Definitions shared by the fetch stage and the instruction decoder:
//   - 3-bit opcode constants (top bits of an 8-bit instruction word)
//   - HALT_WORD, the in-stream word that stops the fetch stage
//   - fetch_state_t, the run/halt state encoding of fetch_unit
// No ports (package).
// -----------------------------------------------------------------------------
package jsilicon_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_MOD = 3'b100;
    localparam logic [2:0] OP_CMP = 3'b101;
    localparam logic [2:0] OP_HLT = 3'b111;

    // Halt opcode with an all-ones operand.
    localparam logic [7:0] HALT_WORD = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } fetch_state_t;

endpackage : jsilicon_pkg

// File: rtl/fetch_imem.sv
// -----------------------------------------------------------------------------
// fetch_imem
// DEPTH x 8 instruction store: synchronous write, combinational read.
// Ports:
//   clock  in   system clock (write edge)
//   we     in   write enable
//   waddr  in   write address [PC_W-1:0]
//   wdata  in   write data [7:0]
//   raddr  in   read address [PC_W-1:0]
//   rdata  out  read data [7:0], combinational from raddr
// -----------------------------------------------------------------------------
module fetch_imem #(
    parameter int DEPTH = 16,
    parameter int PC_W  = 4
) (
    input  logic            clock,
    input  logic            we,
    input  logic [PC_W-1:0] waddr,
    input  logic [7:0]      wdata,
    input  logic [PC_W-1:0] raddr,
    output logic [7:0]      rdata
);

    logic [7:0] mem [DEPTH];

    // NOTE: the array has no reset on purpose; fetch_unit clears prog_len on
    // reset, so stale contents are never fetched, and a reset-free array
    // maps onto plain register files / distributed RAM.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : fetch_imem

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage feeding the decoder. Holds a loadable instruction
// memory and a program counter; issues one registered 8-bit word per enabled
// cycle under an IDLE/LOAD/RUN/HALT state machine.
//
// Build option: FETCH_LOOP_EN
//   defined   - after the last program word, pc wraps to 0 and RUN continues
//   undefined - after the last program word, the FSM halts with pc on it
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   ena          in   global enable shared with the decoder
//   load_start   in   request a program (re)load (IDLE and HALT only)
//   load_valid   in   load_data valid
//   load_last    in   final program word marker
//   load_data    in   [7:0] word to write
//   load_ready   out  high in LOAD
//   run          in   level: run / stop
//   instr_out    out  [7:0] issued instruction (registered)
//   instr_valid  out  instr_out is fresh this cycle
//   pc           out  [PC_W-1:0] address of next fetch
//   halted       out  high in HALT
// -----------------------------------------------------------------------------
module fetch_unit
    import jsilicon_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PC_W  = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            ena,
    input  logic            load_start,
    input  logic            load_valid,
    input  logic            load_last,
    input  logic [7:0]      load_data,
    output logic            load_ready,
    input  logic            run,
    output logic [7:0]      instr_out,
    output logic            instr_valid,
    output logic [PC_W-1:0] pc,
    output logic            halted
);

    localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(DEPTH - 1);
    localparam logic [PC_W:0]   LEN_ONE = (PC_W + 1)'(1);

    fetch_state_t    state,       state_next;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] wr_ptr,      wr_ptr_next;
    logic [PC_W:0]   prog_len,    prog_len_next;   // 0..DEPTH
    logic [7:0]      instr_out_next;
    logic            instr_valid_next;
    logic            mem_we;
    logic [7:0]      fetch_word;
    logic            last_word;

    fetch_imem #(
        .DEPTH (DEPTH),
        .PC_W  (PC_W)
    ) u_imem (
        .clock (clock),
        .we    (mem_we),
        .waddr (wr_ptr),
        .wdata (load_data),
        .raddr (pc),
        .rdata (fetch_word)
    );

    // pc is on the final program word (prog_len is never 0 while in RUN).
    assign last_word = ({1'b0, pc} == (prog_len - LEN_ONE));

    assign load_ready = (state == ST_LOAD);
    assign halted     = (state == ST_HALT);

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_next       = state;
        pc_next          = pc;
        wr_ptr_next      = wr_ptr;
        prog_len_next    = prog_len;
        instr_out_next   = instr_out;
        instr_valid_next = 1'b0;
        mem_we           = 1'b0;

        case (state)
            ST_IDLE: begin
                if (load_start) begin
                    state_next    = ST_LOAD;
                    wr_ptr_next   = '0;
                    prog_len_next = '0;
                end else if (run && (prog_len != '0)) begin
                    state_next = ST_RUN;
                    pc_next    = '0;
                end
            end

            ST_LOAD: begin
                if (load_valid) begin
                    mem_we        = 1'b1;
                    wr_ptr_next   = wr_ptr + PC_ONE;
                    prog_len_next = prog_len + LEN_ONE;
                    // Leaving on the word that fills the memory means no
                    // word past DEPTH is ever accepted.
                    if (load_last || (wr_ptr == PC_LAST)) begin
                        state_next = ST_IDLE;
                    end
                end
            end

            ST_RUN: begin
                if (!run) begin
                    state_next = ST_IDLE;
                end else if (ena) begin
                    if (fetch_word == HALT_WORD) begin
                        // Halt word is not issued; pc stays on it.
                        state_next = ST_HALT;
                    end else begin
                        instr_out_next   = fetch_word;
                        instr_valid_next = 1'b1;
                        if (last_word) begin
`ifdef FETCH_LOOP_EN
                            pc_next = '0;
`else
                            state_next = ST_HALT;
`endif
                        end else begin
                            pc_next = pc + PC_ONE;
                        end
                    end
                end
            end

            ST_HALT: begin
                if (load_start) begin
                    state_next    = ST_LOAD;
                    wr_ptr_next   = '0;
                    prog_len_next = '0;
                end else if (!run) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            pc          <= '0;
            wr_ptr      <= '0;
            prog_len    <= '0;
            instr_out   <= 8'h00;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            wr_ptr      <= wr_ptr_next;
            prog_len    <= prog_len_next;
            instr_out   <= instr_out_next;
            instr_valid <= instr_valid_next;
        end
    end

endmodule : fetch_unit
